keypad_scan_encoder: RTL and testbench

KEYPAD_SCAN_ENCODER -- requirements
Module: keypad_scan_encoder

---
 rtl/keypad_scan_encoder.sv | 147 ++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: walks one active-low row at a time, debounces a
// single-column hit, then reports one code per press and tracks its release.
module keypad_scan_encoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t          state, state_next;
  logic [3:0]      col_meta, col_sync;
  logic [DW-1:0]   dwell;
  logic            tick;
  logic [1:0]      row_idx, row_idx_next;
  logic [CW-1:0]   deb_cnt, deb_next;
  logic [CW-1:0]   rel_cnt, rel_next;
  logic [1:0]      lat_row, lat_row_next;
  logic [1:0]      lat_col, lat_col_next;
  logic [3:0]      key_code_next;
  logic            key_valid_next, key_held_next;
  logic [3:0]      low, lat_mask;
  logic            single_low;
  logic [1:0]      low_col;

  assign tick       = (dwell == DW'(SCAN_DIV - 1));
  assign low        = ~col_sync;
  assign single_low = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
  assign lat_mask   = 4'b0001 << lat_col;

  always_comb begin
    low_col = 2'd0;
    case (low)
      4'b0010: low_col = 2'd1;
      4'b0100: low_col = 2'd2;
      4'b1000: low_col = 2'd3;
      default: low_col = 2'd0;
    endcase
  end

  // Column lines are asynchronous to clk; the reset value reads as "no key".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
      dwell    <= '0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
      dwell    <= tick ? '0 : dwell + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      row_out   <= 4'b1110;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      row_idx   <= row_idx_next;
      row_out   <= ~(4'b0001 << row_idx_next);
      deb_cnt   <= deb_next;
      rel_cnt   <= rel_next;
      lat_row   <= lat_row_next;
      lat_col   <= lat_col_next;
      key_code  <= key_code_next;
      key_valid <= key_valid_next;
      key_held  <= key_held_next;
    end
  end

  // Accept and release act on the clock after the count reaches its target,
  // so they take priority over any tick handling in that state.
  always_comb begin
    state_next     = state;
    row_idx_next   = row_idx;
    deb_next       = deb_cnt;
    rel_next       = rel_cnt;
    lat_row_next   = lat_row;
    lat_col_next   = lat_col;
    key_code_next  = key_code;
    key_valid_next = 1'b0;
    key_held_next  = key_held;
    case (state)
      SCAN: begin
        if (tick) begin
          if (single_low) begin
            lat_row_next = row_idx;
            lat_col_next = low_col;
            deb_next     = CW'(1);
            state_next   = DEBOUNCE;
          end else begin
            row_idx_next = row_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (deb_cnt == CW'(DEBOUNCE_CNT)) begin
          key_valid_next = 1'b1;
          key_code_next  = {lat_row, lat_col};
          key_held_next  = 1'b1;
          deb_next       = '0;
          rel_next       = '0;
          state_next     = HELD;
        end else if (tick) begin
          if (low == lat_mask) begin
            deb_next = deb_cnt + CW'(1);
          end else begin
            deb_next     = '0;
            state_next   = SCAN;
            row_idx_next = row_idx + 2'd1;
          end
        end
      end
      HELD: begin
        if (rel_cnt == CW'(DEBOUNCE_CNT)) begin
          key_held_next = 1'b0;
          rel_next      = '0;
          state_next    = SCAN;
          row_idx_next  = row_idx + 2'd1;
        end else if (tick) begin
          rel_next = (low == 4'b0000) ? rel_cnt + CW'(1) : '0;
        end
      end
      default: state_next = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a virtual 4x4 keypad drives the columns from
// the scanned row; expected key codes go into a queue checked by a monitor.
module tb_keypad_scan_encoder;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed   = 16'h0000;
  logic        force_en  = 1'b1;
  logic [3:0]  force_val = 4'b0000;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int held_row = 0;
  logic prev_held = 1'b0;

  keypad_scan_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Key (r,c) shorts column c to row r: a column reads low only while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    if (force_en) col_in = force_val;
    else
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (!row_out[r] && pressed[4*r+c]) col_in[c] = 1'b0;
  end

  function automatic logic [3:0] rowcode(int r);
    logic [3:0] v;
    v = 4'hF;
    v[r] = 1'b0;
    return v;
  endfunction

  task automatic check(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every accepted press must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_held = 1'b0;
    end else begin
      check("row_onehot", $countones(~row_out), 1);
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_key_valid: got code %0d, expected no pulse at %0t", key_code, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("key_code", key_code, e);
          check("held_on_valid", key_held, 1);
          held_row = e / 4;
        end
      end
      if (prev_held && !key_held)
        check("row_after_release", row_out, rowcode((held_row + 1) % 4));
      prev_held = key_held;
    end
  end

  task automatic applyStimulus();
    int kind, k, c2;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      k    = $urandom_range(0, 15);
      case (kind)
        0: begin
          pressed = 16'h0001 << k;
          exp_q.push_back(k);
          repeat ($urandom_range(60, 120)) @(negedge clk);
          check("held_during_press", key_held, 1);
          check("row_frozen", row_out, rowcode(k / 4));
        end
        1: begin
          pressed = 16'h0001 << k;
          repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        default: begin
          c2 = ((k % 4) + $urandom_range(1, 3)) % 4;
          pressed = (16'h0001 << k) | (16'h0001 << (4 * (k / 4) + c2));
          repeat (80) @(negedge clk);
          check("ghost_not_held", key_held, 0);
        end
      endcase
      pressed = 16'h0000;
      repeat ($urandom_range(40, 60)) @(negedge clk);
      check("released", key_held, 0);
    end
  endtask

  task automatic checkOutput(string tag, logic [3:0] row, logic held);
    check({tag, "_row"}, row_out, row);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_held"}, key_held, held);
  endtask

  initial begin
    // Reset held with all columns low: nothing may move.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("reset", 4'b1110, 1'b0);
    end

    // Idle scan: each row held SCAN_DIV clocks in order.
    force_val = 4'hF;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      check("idle_row", row_out, rowcode((k / SCAN_DIV) % 4));
    end

    // Clean press of row 2 / column 1, then release.
    force_en = 1'b0;
    pressed = 16'h0001 << 9;
    exp_q.push_back(9);
    repeat (80) @(negedge clk);
    check("clean_held", key_held, 1);
    check("clean_row", row_out, 4'b1011);
    check("clean_code", key_code, 9);
    pressed = 16'h0000;
    repeat (40) @(negedge clk);
    check("clean_released", key_held, 0);

    applyStimulus();

    // Reset during debounce: key 2 sits on row 0 so timing is known from reset release.
    @(negedge clk);
    pressed = 16'h0000;
    force_en = 1'b1;
    force_val = 4'hF;
    rst = 1'b1;
    @(negedge clk);
    pressed = 16'h0004;
    force_en = 1'b0;
    rst = 1'b0;
    repeat (9) @(negedge clk);
    check("debounce_frozen_row", row_out, 4'b1110);
    check("debounce_not_held", key_held, 0);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 4'b1110, 1'b0);
    pressed = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check("resume_row", row_out, rowcode((k / SCAN_DIV) % 4));
    end

    repeat (50) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
